// File: rtl/sr_universal_nbit.sv
// Universal WIDTH-bit shift register: hold, shift right/left, parallel load, with shift counter
// and frame_done pulse. Optional rotate feature enabled by defining SR_ROTATE_EN.
module sr_universal_nbit #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
`ifdef SR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;

    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_fd_next;
    logic             w_is_shift;
    logic             w_ins_r;
    logic             w_ins_l;

    // With rotation the outgoing bit is recirculated instead of the serial input.
`ifdef SR_ROTATE_EN
    assign w_ins_r = rot ? r_q[0]       : sin_r;
    assign w_ins_l = rot ? r_q[WIDTH-1] : sin_l;
`else
    assign w_ins_r = sin_r;
    assign w_ins_l = sin_l;
`endif

    // Next-state selection for register contents, counter and frame pulse.
    always_comb begin
        w_q_next   = r_q;
        w_cnt_next = r_cnt;
        w_fd_next  = 1'b0;
        w_is_shift = 1'b0;
        if (en) begin
            case (mode)
                2'b01: begin
                    w_q_next   = {w_ins_r, r_q[WIDTH-1:1]};
                    w_is_shift = 1'b1;
                end
                2'b10: begin
                    w_q_next   = {r_q[WIDTH-2:0], w_ins_l};
                    w_is_shift = 1'b1;
                end
                2'b11: begin
                    w_q_next   = pin;
                    w_cnt_next = CNT_ZERO;
                end
                default: begin
                    w_q_next   = r_q;
                    w_cnt_next = r_cnt;
                end
            endcase
            // Both directions share one counter; the WIDTH-th shift wraps and pulses.
            if (w_is_shift) begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next = CNT_ZERO;
                    w_fd_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                    w_fd_next  = 1'b0;
                end
            end else begin
                w_fd_next = 1'b0;
            end
        end else begin
            w_q_next   = r_q;
            w_cnt_next = r_cnt;
            w_fd_next  = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= RST_VAL;
            r_cnt        <= CNT_ZERO;
            r_frame_done <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_cnt        <= w_cnt_next;
            r_frame_done <= w_fd_next;
        end
    end

    assign pout       = r_q;
    assign sout_r     = r_q[0];
    assign sout_l     = r_q[WIDTH-1];
    assign shift_cnt  = r_cnt;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sr_universal_nbit.sv
// Self-checking bench for sr_universal_nbit (WIDTH=4): directed scenarios plus random traffic
// compared every cycle against an arithmetic model of the register.
module tb_sr_universal_nbit;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] pin;
    logic       rot;
    logic [3:0] pout;
    logic       sout_r;
    logic       sout_l;
    logic [2:0] shift_cnt;
    logic       frame_done;

    int n_vec;
    int n_err;
    bit chk_on;

    int m_q;
    int m_cnt;
    int m_fd;

    sr_universal_nbit #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
`ifdef SR_ROTATE_EN
        .rot        (rot),
`endif
        .pout       (pout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    always #25 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("pout", int'(pout), m_q);
            check("sout_r", int'(sout_r), m_q % 2);
            check("sout_l", int'(sout_l), m_q / 8);
            check("shift_cnt", int'(shift_cnt), m_cnt);
            check("frame_done", int'(frame_done), m_fd);
        end
    end

    // Apply one clock of inputs, advance the model, return at the following falling edge.
    task automatic apply(input bit r, input bit e, input int m, input bit sr, input bit sl,
                         input int p, input bit rt);
        int nq, ncnt, nfd, ins;
        bit use_rot;
        rst = r; en = e; mode = 2'(m); sin_r = sr; sin_l = sl; pin = 4'(p); rot = rt;
`ifdef SR_ROTATE_EN
        use_rot = rt;
`else
        use_rot = 1'b0;
`endif
        nq = m_q; ncnt = m_cnt; nfd = 0;
        if (r) begin
            nq = 0; ncnt = 0;
        end else if (e) begin
            if (m == 3) begin
                nq = p; ncnt = 0;
            end else if (m == 1 || m == 2) begin
                if (m == 1) begin
                    ins = use_rot ? (m_q % 2) : int'(sr);
                    nq = (m_q / 2) + ins * 8;
                end else begin
                    ins = use_rot ? (m_q / 8) : int'(sl);
                    nq = ((m_q * 2) % 16) + ins;
                end
                nfd  = (m_cnt == 3) ? 1 : 0;
                ncnt = (m_cnt + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        m_q = nq; m_cnt = ncnt; m_fd = nfd;
        if (r) chk_on = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int sr_bits[4];
        int des_bits[4];
        clk = 1'b0; rst = 1'b0; en = 1'b0; mode = 2'b00;
        sin_r = 1'b0; sin_l = 1'b0; pin = 4'h0; rot = 1'b0;
        n_vec = 0; n_err = 0; chk_on = 1'b0;
        m_q = 0; m_cnt = 0; m_fd = 0;
        sr_bits  = '{1, 1, 0, 1};
        des_bits = '{0, 1, 0, 1};
        @(negedge clk);

        // Reset priority over en and load
        apply(1, 1, 3, 0, 0, 4'hA, 0);
        check("t1_pout", int'(pout), 0);
        check("t1_cnt", int'(shift_cnt), 0);
        check("t1_fd", int'(frame_done), 0);

        // Serialize 1011
        apply(0, 1, 3, 0, 0, 4'b1011, 0);
        for (int i = 0; i < 4; i++) begin
            check("t2_sout_r", int'(sout_r), sr_bits[i]);
            apply(0, 1, 1, 0, 0, 0, 0);
            check("t2_fd", int'(frame_done), (i == 3) ? 1 : 0);
        end
        check("t2_pout", int'(pout), 0);

        // Deserialize 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 1, des_bits[i] != 0, 0, 0, 0);
            check("t3_fd", int'(frame_done), (i == 3) ? 1 : 0);
        end
        check("t3_pout", int'(pout), 4'b1010);
        check("t3_cnt", int'(shift_cnt), 0);

        // Enable gating
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1, 1, 0, 0);
            check("t4_pout", int'(pout), 4'b1010);
            check("t4_cnt", int'(shift_cnt), 0);
            check("t4_fd", int'(frame_done), 0);
        end

        // Mid-frame restart by reset, then by load
        for (int k = 0; k < 2; k++) begin
            apply(0, 1, 1, 1, 0, 0, 0);
            apply(0, 1, 2, 0, 1, 0, 0);
            check("t5_cnt_mid", int'(shift_cnt), 2);
            if (k == 0) apply(1, 1, 1, 0, 0, 0, 0);
            else        apply(0, 1, 3, 0, 0, 4'h5, 0);
            check("t5_cnt_restart", int'(shift_cnt), 0);
            for (int i = 0; i < 4; i++) begin
                apply(0, 1, 1 + (i % 2), 1, 1, 0, 0);
                check("t5_fd", int'(frame_done), (i == 3) ? 1 : 0);
            end
        end

`ifdef SR_ROTATE_EN
        // Rotate left of 1000
        apply(0, 1, 3, 0, 0, 4'b1000, 0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 2, 0, 0, 0, 1);
            check("t6_pout", int'(pout), (1 << i));
            check("t6_fd", int'(frame_done), (i == 3) ? 1 : 0);
        end
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(31) == 0, $urandom_range(7) != 0, $urandom_range(3),
                  1'($urandom), 1'($urandom), $urandom_range(15), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
